// File: rtl/reward_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// reward_scheduler_pkg
// Shared definitions for the reward scheduler slice:
//   - state_e      : scheduler FSM state encoding
//   - REW_*        : reward / effect type codes seen by reward_display
//   - CNT_MAX      : saturation value of the shared millisecond counter
//   - lfsr16_next  : one step of the 16-bit Fibonacci LFSR
//   - sat_inc16    : saturating increment for the shared counter
// ---------------------------------------------------------------------------
package reward_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DRAW   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_EFFECT = 3'd4
    } state_e;

    localparam logic [2:0] REW_NONE    = 3'd0;
    localparam logic [2:0] REW_PROTECT = 3'd1;
    localparam logic [2:0] REW_FASTER  = 3'd2;
    localparam logic [2:0] REW_FROZEN  = 3'd3;
    localparam logic [2:0] REW_LASER   = 3'd4;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Taps 16,14,13,11 give a maximal-length sequence, so any nonzero seed
    // walks all 65535 nonzero states before repeating.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == CNT_MAX) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/reward_scheduler_lfsr16.sv
// ---------------------------------------------------------------------------
// reward_lfsr16
// Free-running 16-bit Fibonacci LFSR. Advances on every clock edge while out
// of reset; only reset reloads the seed.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, loads SEED
//   q_o     : current LFSR state
// ---------------------------------------------------------------------------
module reward_lfsr16
    import reward_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value is a pure shift with feedback; there is no enable because
    // the scheduler wants the sequence to keep moving even while idle.
    always_comb begin
        lfsr_d = lfsr16_next(lfsr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/reward_scheduler.sv
// ---------------------------------------------------------------------------
// reward_scheduler
// Sequences the on-screen reward: waits a spawn delay, draws a random grid
// cell and type from an LFSR, shows it until the player drives over it or it
// times out, then runs the effect timer after a pickup.
// Ports:
//   clk_i                  : system clock
//   rst_ni                 : asynchronous active-low reset
//   tick_ms_i              : one-cycle pulse once per millisecond
//   enable_game_classic_i  : classic mode running
//   enable_game_infinity_i : infinity mode running
//   player_xpos_i/ypos_i   : player tank grid position
//   set_require_o          : reward visible
//   random_xpos_o/ypos_o   : reward grid position
//   reward_type_o          : 1=protect/addtime, 2=faster, 3=frozen, 4=laser
//   reward_taken_o         : one-cycle pulse on pickup
//   effect_type_o          : type of the running effect, 0 when none
//   effect_active_o        : high while the effect runs
// ---------------------------------------------------------------------------
module reward_scheduler
    import reward_scheduler_pkg::*;
#(
    parameter int unsigned SPAWN_DELAY_MS = 5000,
    parameter int unsigned LIFETIME_MS    = 8000,
    parameter int unsigned EFFECT_MS      = 10000,
    parameter int unsigned GRID_X_MAX     = 23,
    parameter int unsigned GRID_Y_MAX     = 15,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_ms_i,
    input  logic       enable_game_classic_i,
    input  logic       enable_game_infinity_i,
    input  logic [4:0] player_xpos_i,
    input  logic [4:0] player_ypos_i,
    output logic       set_require_o,
    output logic [4:0] random_xpos_o,
    output logic [4:0] random_ypos_o,
    output logic [2:0] reward_type_o,
    output logic       reward_taken_o,
    output logic [2:0] effect_type_o,
    output logic       effect_active_o
);

    localparam logic [15:0] SPAWN_LAST  = 16'(SPAWN_DELAY_MS - 1);
    localparam logic [15:0] LIFE_LAST   = 16'(LIFETIME_MS - 1);
    localparam logic [15:0] EFFECT_LAST = 16'(EFFECT_MS - 1);
    localparam logic [4:0]  X_MAX       = 5'(GRID_X_MAX);
    localparam logic [4:0]  Y_MAX       = 5'(GRID_Y_MAX);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  randX_q, randX_d;
    logic [4:0]  randY_q, randY_d;
    logic [2:0]  rewardType_q, rewardType_d;
    logic [2:0]  effectType_q, effectType_d;
    logic        rewardTaken_q, rewardTaken_d;

    logic [15:0] lfsr;
    logic        gameOn;
    logic [4:0]  candX;
    logic [4:0]  candY;
    logic [2:0]  candT;
    logic        candOk;
    logic        hit;
    logic        unusedBits;

    reward_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .q_o    (lfsr)
    );

    // Bits 12:10 only feed the LFSR itself; the candidate draw skips them.
    assign unusedBits = ^lfsr[12:10];

    assign gameOn = enable_game_classic_i | enable_game_infinity_i;
    assign candX  = lfsr[4:0];
    assign candY  = lfsr[9:5];
    assign candT  = lfsr[15:13];
    assign candOk = (candX <= X_MAX) && (candY <= Y_MAX) &&
                    (candT inside {REW_PROTECT, REW_FASTER, REW_FROZEN, REW_LASER});
    assign hit    = (player_xpos_i == randX_q) && (player_ypos_i == randY_q);

    // Next-state logic. A dropped game mode overrides everything and parks the
    // FSM in IDLE, but the last drawn cell is kept so reward_display does not
    // jump while the screen is being torn down. Within ACTIVE a pickup is
    // checked before the lifetime expiry so a last-moment hit still counts.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        randX_d       = randX_q;
        randY_d       = randY_q;
        rewardType_d  = rewardType_q;
        effectType_d  = effectType_q;
        rewardTaken_d = 1'b0;

        if (!gameOn) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            effectType_d = REW_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    if (tick_ms_i) begin
                        if (cnt_q == SPAWN_LAST) begin
                            state_d = ST_DRAW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end
                end
                ST_DRAW: begin
                    if (candOk) begin
                        state_d      = ST_ACTIVE;
                        cnt_d        = '0;
                        randX_d      = candX;
                        randY_d      = candY;
                        rewardType_d = candT;
                    end
                end
                ST_ACTIVE: begin
                    if (hit) begin
                        state_d       = ST_EFFECT;
                        cnt_d         = '0;
                        rewardTaken_d = 1'b1;
                        effectType_d  = rewardType_q;
                    end else if (tick_ms_i) begin
                        if (cnt_q == LIFE_LAST) begin
                            state_d = ST_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end
                end
                ST_EFFECT: begin
                    if (tick_ms_i) begin
                        if (cnt_q == EFFECT_LAST) begin
                            state_d      = ST_WAIT;
                            cnt_d        = '0;
                            effectType_d = REW_NONE;
                        end else begin
                            cnt_d = sat_inc16(cnt_q);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and latched reward registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            randX_q       <= '0;
            randY_q       <= '0;
            rewardType_q  <= REW_NONE;
            effectType_q  <= REW_NONE;
            rewardTaken_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            randX_q       <= randX_d;
            randY_q       <= randY_d;
            rewardType_q  <= rewardType_d;
            effectType_q  <= effectType_d;
            rewardTaken_q <= rewardTaken_d;
        end
    end

    assign set_require_o   = (state_q == ST_ACTIVE);
    assign effect_active_o = (state_q == ST_EFFECT);
    assign random_xpos_o   = randX_q;
    assign random_ypos_o   = randY_q;
    assign reward_type_o   = rewardType_q;
    assign effect_type_o   = effectType_q;
    assign reward_taken_o  = rewardTaken_q;

endmodule
